mmio_sync_gen: RTL and testbench

Upstream companion of the break generator. Captures core MMIO writes into a small FIFO and emits the `sync_valid` pulse that makes the break generator raise its MMIO break. Presents each captured write to the host/partner side over a valid/ready handshake, then emits the `turn2run` pulse that releases the break once the host reports completion. Also drives `irq2_full` when the capture FIFO is full.

---
 rtl/mmio_sync_pkg.sv | 22 ++
 rtl/mmio_cap_fifo.sv | 56 +++++
 rtl/mmio_sync_gen.sv | 125 ++++++++++++
 tb/tb_mmio_sync_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_sync_pkg.sv
// Shared types for the MMIO sync generator: round FSM states and the captured
// write entry.
package mmio_sync_pkg;

  localparam int ENTRY_ADDR_W = 32;
  localparam int ENTRY_DATA_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_RUN  = 3'd4,
    ST_HOLD = 3'd5
  } sync_state_e;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] data;
  } mmio_entry_t;

endpackage

// File: rtl/mmio_cap_fifo.sv
// Synchronous capture FIFO: wrapping pointers plus a separate occupancy count,
// head entry read combinationally from storage.
module mmio_cap_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is datapath only; stale contents are harmless once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mmio_sync_gen.sv
// Captures core MMIO writes and runs one sync / host-handshake / release round
// per captured entry, in order.
module mmio_sync_gen
  import mmio_sync_pkg::*;
#(
  parameter int ADDR_W  = ENTRY_ADDR_W,
  parameter int DATA_W  = ENTRY_DATA_W,
  parameter int DEPTH   = 4,
  parameter int RUN_GAP = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    isMMIO,
  input  logic                    wenable,
  input  logic [ADDR_W-1:0]       mmio_addr,
  input  logic [DATA_W-1:0]       mmio_wdata,
  output logic                    host_valid,
  output logic [ADDR_W-1:0]       host_addr,
  output logic [DATA_W-1:0]       host_data,
  input  logic                    host_ready,
  input  logic                    host_done,
  output logic                    sync_valid,
  output logic                    turn2run,
  output logic                    irq2_full,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    drop_sticky
);

  localparam int HOLD_W = $clog2(RUN_GAP);

  sync_state_e       state_q;
  logic              sync_valid_q, host_valid_q, turn2run_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              drop_sticky_q, drop_sticky_d;
  logic              capture, push, pop, full;
  logic [$clog2(DEPTH):0] count;
  mmio_entry_t       wr_entry, head;

  // Push is gated by the registered full flag, so a same-cycle pop at full
  // does not make room for the incoming write.
  assign capture = isMMIO && wenable;
  assign push    = capture && !full;
  assign pop     = host_valid_q && host_ready;

  always_comb begin
    wr_entry.addr = mmio_addr;
    wr_entry.data = mmio_wdata;
  end

  mmio_cap_fifo #(
    .WIDTH ($bits(mmio_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .full  (full),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sync_valid_q <= 1'b0;
      host_valid_q <= 1'b0;
      turn2run_q   <= 1'b0;
      hold_cnt_q   <= '0;
    end else begin
      sync_valid_q <= 1'b0;
      turn2run_q   <= 1'b0;
      case (state_q)
        ST_IDLE: if (count != '0) begin
          state_q      <= ST_SYNC;
          sync_valid_q <= 1'b1;
        end
        ST_SYNC: begin
          state_q      <= ST_SEND;
          host_valid_q <= 1'b1;
        end
        ST_SEND: if (host_ready) begin
          state_q      <= ST_WAIT;
          host_valid_q <= 1'b0;
        end
        ST_WAIT: if (host_done) begin
          state_q    <= ST_RUN;
          turn2run_q <= 1'b1;
        end
        ST_RUN: begin
          state_q    <= ST_HOLD;
          hold_cnt_q <= '0;
        end
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_W'(RUN_GAP - 1)) state_q <= ST_IDLE;
          else hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
        end
        default: begin
          state_q      <= ST_IDLE;
          host_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    drop_sticky_d = drop_sticky_q | (capture & full);
  end

  always_ff @(posedge clk) begin
    if (reset) drop_sticky_q <= 1'b0;
    else       drop_sticky_q <= drop_sticky_d;
  end

  assign host_valid  = host_valid_q;
  assign host_addr   = head.addr;
  assign host_data   = head.data;
  assign sync_valid  = sync_valid_q;
  assign turn2run    = turn2run_q;
  assign irq2_full   = full;
  assign fifo_count  = count;
  assign drop_sticky = drop_sticky_q;

endmodule

// File: tb/tb_mmio_sync_gen.sv
// Randomized and directed bench for mmio_sync_gen, checked every cycle against a
// queue-and-timestamp reference model of the capture/round behaviour.
module tb_mmio_sync_gen;

  localparam int DEPTH   = 4;
  localparam int RUN_GAP = 4;

  logic        clk = 1'b0;
  logic        reset, isMMIO, wenable, host_ready, host_done;
  logic [31:0] mmio_addr, host_addr;
  logic [63:0] mmio_wdata, host_data;
  logic        host_valid, sync_valid, turn2run, irq2_full, drop_sticky;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  mmio_sync_gen #(
    .ADDR_W (32), .DATA_W (64), .DEPTH (DEPTH), .RUN_GAP (RUN_GAP)
  ) dut (
    .clk (clk), .reset (reset), .isMMIO (isMMIO), .wenable (wenable),
    .mmio_addr (mmio_addr), .mmio_wdata (mmio_wdata),
    .host_valid (host_valid), .host_addr (host_addr), .host_data (host_data),
    .host_ready (host_ready), .host_done (host_done),
    .sync_valid (sync_valid), .turn2run (turn2run), .irq2_full (irq2_full),
    .fifo_count (fifo_count), .drop_sticky (drop_sticky)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [63:0] d;
  } ent_t;

  // Reference model: pending writes in a queue, round progress as timestamps.
  ent_t mq[$];
  bit   m_drop, m_in_round, m_sending, m_waiting;
  int   m_sync_cyc, m_turn_cyc, m_idle_at;
  int   cyc, last_turn, dut_turns;
  int   n_checks, n_pass;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_step(input bit rst, input bit cap, input bit rdy, input bit dn,
                            input ent_t e);
    int  sz;
    bit  pop;
    if (rst) begin
      mq.delete();
      m_drop = 0; m_in_round = 0; m_sending = 0; m_waiting = 0;
      m_sync_cyc = -100; m_turn_cyc = -100; m_idle_at = cyc;
      return;
    end
    sz  = mq.size();
    pop = m_sending && rdy;
    if (!m_in_round && (cyc - 1) >= m_idle_at && sz > 0) begin
      m_in_round = 1; m_sync_cyc = cyc;
    end else if (m_in_round && (cyc - 1) == m_sync_cyc) begin
      m_sending = 1;
    end else if (pop) begin
      m_sending = 0; m_waiting = 1;
    end else if (m_waiting && dn) begin
      m_waiting = 0; m_turn_cyc = cyc;
    end else if (m_in_round && (cyc - 1) == m_turn_cyc) begin
      m_in_round = 0; m_idle_at = m_turn_cyc + RUN_GAP + 1;
    end
    if (pop) void'(mq.pop_front());
    if (cap) begin
      if (sz == DEPTH) m_drop = 1;
      else mq.push_back(e);
    end
  endtask

  task automatic compare_all();
    chk("sync_valid", sync_valid, (cyc == m_sync_cyc));
    chk("turn2run", turn2run, (cyc == m_turn_cyc));
    chk("host_valid", host_valid, m_sending);
    chk("fifo_count", fifo_count, mq.size());
    chk("irq2_full", irq2_full, (mq.size() == DEPTH));
    chk("drop_sticky", drop_sticky, m_drop);
    if (m_sending) begin
      chk("host_addr", host_addr, mq[0].a);
      chk("host_data", host_data, mq[0].d);
    end
    if (turn2run === 1'b1) begin
      last_turn = cyc;
      dut_turns++;
    end
    if (sync_valid === 1'b1 && last_turn >= 0)
      chk("sync_gap", ((cyc - last_turn) >= RUN_GAP + 2), 1'b1);
  endtask

  task automatic tick(input bit rst, input bit cap, input logic [31:0] a,
                      input logic [63:0] d, input bit rdy, input bit dn);
    ent_t e;
    e.a = a; e.d = d;
    reset = rst;
    if (cap) {isMMIO, wenable} = 2'b11;
    else     {isMMIO, wenable} = 2'($urandom_range(0, 2));
    mmio_addr  = a;
    mmio_wdata = d;
    host_ready = rdy;
    host_done  = dn;
    @(posedge clk);
    cyc++;
    model_step(rst, cap, rdy, dn, e);
    if (rst) last_turn = -1;
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input int rdy_pct, input int dn_pct);
    for (int i = 0; i < n; i++)
      tick(0, 0, $urandom, {$urandom, $urandom},
           ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 99) < dn_pct));
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d);
    tick(0, 1, a, d, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (mq.size() != 0 || m_in_round); i++) idle(1, 100, 100);
    idle(RUN_GAP + 2, 0, 0);
    chk("drained", fifo_count, 0);
  endtask

  task automatic to_send();
    for (int i = 0; i < 20 && host_valid !== 1'b1; i++) idle(1, 0, 0);
    chk("reach_send", host_valid, 1'b1);
  endtask

  int t0;

  initial begin
    cyc = 0; last_turn = -1; dut_turns = 0; n_checks = 0; n_pass = 0;
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    idle(3, 0, 0);

    // Single write, then handshake and completion.
    t0 = dut_turns;
    wr(32'h1000_0000, 64'hDEAD_BEEF);
    idle(4, 0, 0);
    idle(1, 100, 0);
    idle(4, 0, 0);
    idle(1, 0, 100);
    idle(12, 0, 0);
    chk("single_turns", dut_turns - t0, 1);

    // Three back-to-back writes serviced in order.
    t0 = dut_turns;
    wr(32'hA, 64'hA); wr(32'hB, 64'hB); wr(32'hC, 64'hC);
    idle(90, 60, 40);
    drain();
    chk("three_turns", dut_turns - t0, 3);

    // Overflow with the host stalled.
    for (int i = 0; i < 5; i++) wr($urandom, {$urandom, $urandom});
    chk("ovf_full", irq2_full, 1'b1);
    chk("ovf_drop", drop_sticky, 1'b1);
    chk("ovf_count", fifo_count, 4);
    idle(1, 100, 0);
    chk("full_after_pop", irq2_full, 1'b0);
    drain();

    // Push and pop in the same cycle at count 2.
    wr(32'h21, 64'h21); wr(32'h22, 64'h22);
    to_send();
    tick(0, 1, 32'h23, 64'h23, 1, 0);
    chk("pushpop_count", fifo_count, 2);
    drain();

    // host_done outside WAIT is ignored.
    t0 = dut_turns;
    idle(3, 0, 100);
    wr(32'h31, 64'h31);
    to_send();
    idle(4, 0, 100);
    chk("no_spurious_turn", dut_turns - t0, 0);
    drain();

    // Reset in the middle of a round.
    t0 = dut_turns;
    wr(32'h41, 64'h41);
    to_send();
    idle(1, 100, 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_host_valid", host_valid, 1'b0);
    idle(RUN_GAP + 4, 0, 100);
    chk("rst_no_turn", dut_turns - t0, 0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++)
      tick(($urandom_range(0, 399) == 0), ($urandom_range(0, 99) < 30),
           $urandom, {$urandom, $urandom},
           ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 30));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
